stream_demux_reg: RTL
=====================

// Module: stream_demux_reg
// PURPOSE
//  Registered 1-to-N stream demultiplexer with valid/ready handshakes. It is
//  the inverse of the mux: one input stream is steered by in_sel to one of
//  N_OUT output streams. Each output has a one-entry holding register, so a
//  stalled output never blocks traffic bound for the other outputs. Sits
//  between a single producer and N independent consumers.
// PARAMETERS
//  N_OUT  default 4  number of output channels, >= 2
//  W      default 8  data width in bits
//  SW     default $clog2(N_OUT)  select width (derived, do not override)
// PORTS
//  clk        in   1        clock, all state updates on the rising edge
//  rst_n      in   1        asynchronous reset, active-low
//  in_valid   in   1        producer offers in_data/in_sel
//  in_ready   out  1        demux accepts the word this cycle
//  in_data    in   W        payload
//  in_sel     in   SW       destination channel index
//  out_valid  out  N_OUT    bit k: channel k holds a word
//  out_ready  in   N_OUT    bit k: consumer k takes the word
//  out_data   out  N_OUT*W  channel k payload is bits [k*W +: W]
//  drop       out  1        1-cycle pulse: a word with out-of-range in_sel was discarded
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, out_data=0, drop=0, and the drop
//    counter (when present) = 0. Words held at reset are lost, not flushed.
//  - Per-channel state: valid_q[k] and data_q[k]. out_valid[k]=valid_q[k] and
//    out_data[k]=data_q[k], both driven directly from registers.
//  - Define s = in_sel.
//    - in_ready = (s >= N_OUT) | ~valid_q[s] | out_ready[s].
//    - This path is combinational from in_sel/out_ready (not from in_valid).
//  - Accept: in_valid & in_ready & s < N_OUT loads data_q[s] <= in_data and
//    sets valid_q[s] <= 1.
//    - Latency: word accepted at edge t appears on out_valid[s] after edge t.
//  - Drain: out_valid[k] & out_ready[k] clears valid_q[k], unless channel k is
//    loaded in the same cycle. Load and drain together leave valid=1 with the
//    new data, sustaining one word per cycle on a channel.
//  - Stall: while out_valid[k]=1 & out_ready[k]=0, data_q[k] stays stable.
//    Other channels keep accepting and draining independently.
//  - Out-of-range select (possible only when N_OUT is not a power of 2):
//    - the word is accepted (in_ready=1) and discarded;
//    - drop=1 for the cycle after acceptance; no channel state changes.
//  - in_sel and in_data are ignored while in_valid=0.
//  - Several outputs may be valid at once. Draining them in parallel is legal.
//  - Ordering is preserved per channel only. Words never reorder within a
//    channel.
//  - data_q[k] is not cleared on drain. It only changes on a load.
// CONFIGURATION
//  Macro STREAM_DEMUX_REG_DROP_CNT_EN:
//  - Defined: adds port drop_cnt (out, 8). It counts dropped words, saturates
//    at 255 and is cleared only by reset. It updates on the same edge that
//    sets drop.
//  - Not defined: drop_cnt port and counter are absent. All other behaviour
//    is identical.
// TESTING
//  1. Reset: rst_n=0 mid-stream with channel 2 valid
//     -> out_valid=0000, out_data=0 and drop=0 immediately, before any clk
//        edge.
//  2. Single word: in_valid=1, sel=1, data=8'hA5, out_ready=0
//     -> next cycle out_valid=0010 and ch1 data A5.
//     Then hold sel=1 with new data 8'h3C -> in_ready=0 and ch1 still shows
//     A5 until out_ready[1]=1.
//  3. Back-to-back: sel=3, data 1,2,3,4 on consecutive cycles, out_ready[3]=1
//     -> in_ready=1 every cycle; ch3 shows 1,2,3,4 on consecutive cycles.
//  4. Isolation: ch0 full and stalled (out_ready[0]=0); send sel=2, data=8'h77
//     -> accepted; out_valid=0101; ch0 data unchanged.
//  5. Out of range: N_OUT=3, sel=3, in_valid=1
//     -> in_ready=1; drop pulses 1 cycle; out_valid unchanged.
//     With the macro defined: drop_cnt increments by 1. After 300 drops
//     drop_cnt=255.
//  6. Random: random valid/ready/sel for 10k cycles, checked against a
//     per-channel FIFO scoreboard -> no loss, duplication or reordering; data
//     stable while stalled.

Source files
------------

// File: rtl/stream_demux_reg_if.sv
// Handshake bundle for stream_demux_reg: one producer-side stream, N_OUT consumer streams
// and the drop pulse. The slave modport is the demux view; the master modport is its environment.
interface stream_demux_reg_if #(
   parameter int N_OUT = 4,
   parameter int W     = 8
) ();
   localparam int SW = $clog2(N_OUT);

   logic                 in_valid;
   logic                 in_ready;
   logic [W-1:0]         in_data;
   logic [SW-1:0]        in_sel;
   logic [N_OUT-1:0]     out_valid;
   logic [N_OUT-1:0]     out_ready;
   logic [N_OUT*W-1:0]   out_data;
   logic                 drop;

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, drop
   );

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, drop
   );
endinterface

// File: rtl/stream_demux_reg.sv
// Registered 1-to-N valid/ready demultiplexer with a one-word holding register per output.
// Optional feature macro STREAM_DEMUX_REG_DROP_CNT_EN adds the saturating drop_cnt output.
module stream_demux_reg #(
   parameter int N_OUT = 4,
   parameter int W     = 8,
   parameter int SW    = $clog2(N_OUT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   stream_demux_reg_if.slave     bus
`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
   ,
   output logic [7:0]            drop_cnt
`endif
);

   localparam logic [SW:0] NOUT_L = (SW+1)'(N_OUT);

   logic [N_OUT-1:0]          valid_r;
   logic [N_OUT-1:0][W-1:0]   data_r;
   logic                      drop_r;

   logic                      sel_ok_s;
   logic [N_OUT-1:0]          hit_s;
   logic [N_OUT-1:0]          load_s;
   logic                      ready_s;
   logic                      accept_s;

   // Select decode, ready (independent of in_valid) and per-channel load enables
   always_comb begin
      sel_ok_s = ({1'b0, bus.in_sel} < NOUT_L);
      hit_s    = {N_OUT{1'b0}};
      for (int k = 0; k < N_OUT; k++) begin
         hit_s[k] = sel_ok_s && (bus.in_sel == SW'(k));
      end
      // An out-of-range word is always taken so it can be discarded
      ready_s  = ~sel_ok_s | (|(hit_s & (~valid_r | bus.out_ready)));
      accept_s = bus.in_valid & ready_s;
      if (accept_s) begin
         load_s = hit_s;
      end else begin
         load_s = {N_OUT{1'b0}};
      end
   end

   // Channel holding registers: a load wins over a drain so a channel can stream every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {N_OUT{1'b0}};
         data_r  <= {(N_OUT*W){1'b0}};
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (load_s[k]) begin
               valid_r[k] <= 1'b1;
               data_r[k]  <= bus.in_data;
            end else if (bus.out_ready[k]) begin
               valid_r[k] <= 1'b0;
            end else begin
               valid_r[k] <= valid_r[k];
            end
         end
      end
   end

   // Drop pulse for a discarded out-of-range word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_r <= 1'b0;
      end else begin
         drop_r <= accept_s & ~sel_ok_s;
      end
   end

`ifdef STREAM_DEMUX_REG_DROP_CNT_EN
   logic [7:0] drop_cnt_r;

   // Saturating count of discarded words, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_r <= 8'd0;
      end else if (accept_s && !sel_ok_s && (drop_cnt_r != 8'hFF)) begin
         drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign drop_cnt = drop_cnt_r;
`endif

   assign bus.in_ready  = ready_s;
   assign bus.out_valid = valid_r;
   assign bus.out_data  = data_r;
   assign bus.drop      = drop_r;

endmodule
